// File: rtl/mbu_bank_select.sv
// -----------------------------------------------------------------------------
// mbu_bank_select
//
// Memory Banking Unit. Holds the four bank registers MB0-MB3 and produces the
// registered 8-bit extended address (aext) that feeds the upper byte of the
// Address Register.
//
// Bank choice:
//   - bank_sel picks Program (MB0), Data (MB1), Stack (MB2) or MB3.
//   - A page-zero access (top P0_BITS of addr all zero) always uses MB3.
//   - With banking disabled (control bit 0 clear), aext is forced to zero.
//
// A write to MB0 does not take effect immediately. The value is parked in a
// pending register until the next instruction fetch (fetch_commit). This lets
// a far jump load the new program bank and branch without executing from a
// half-switched address space.
//
// Register map on raddr (all registers are 8 bits wide, read back zero-extended):
//   5'b00011  control   bit0 = banking enable; bits 7:1 read as 0
//   5'b00100  MB0       reads the pending value while a commit is outstanding
//   5'b00101  MB1
//   5'b00110  MB2
//   5'b00111  MB3
//   Any other raddr is ignored on writes and does not drive the bus on reads.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   raddr           register address
//   wen / ren       write / read strobes (single-cycle qualifiers, no stall)
//   ibus_in         write data, low byte used
//   ibus_out        read data {8'h00, reg}, zero when not driving
//   ibus_oe         high while ibus_out carries a decoded register
//   bank_sel        microcode bank selector
//   addr            address being loaded into AR
//   fetch_commit    one-cycle pulse at instruction fetch
//   aext            registered extended address
//   mb0_pending     a deferred MB0 write is waiting for fetch_commit
// -----------------------------------------------------------------------------
module mbu_bank_select #(
    parameter int   P0_BITS  = 6,
    parameter logic RESET_EN = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  raddr,
    input  logic        wen,
    input  logic        ren,
    input  logic [15:0] ibus_in,
    output logic [15:0] ibus_out,
    output logic        ibus_oe,
    input  logic [1:0]  bank_sel,
    input  logic [15:0] addr,
    input  logic        fetch_commit,
    output logic [7:0]  aext,
    output logic        mb0_pending
);

    localparam logic [4:0] RA_CTRL = 5'b00011;
    localparam logic [4:0] RA_MB0  = 5'b00100;
    localparam logic [4:0] RA_MB1  = 5'b00101;
    localparam logic [4:0] RA_MB2  = 5'b00110;
    localparam logic [4:0] RA_MB3  = 5'b00111;

    logic [7:0] mb [0:3];
    logic [7:0] pmb0;
    logic       pending;
    logic       en;

    logic       page_zero;
    logic [1:0] bank_idx;
    logic [7:0] rd_byte;
    logic       rd_hit;

    // Only the low byte of the bus and the high address bits matter here.
    logic unused_bits;
    assign unused_bits = ^{ibus_in[15:8], addr[15-P0_BITS:0]};

    assign page_zero   = (addr[15 -: P0_BITS] == '0);
    assign bank_idx    = page_zero ? 2'd3 : bank_sel;
    assign mb0_pending = pending;

    // -------------------------------------------------------------------------
    // Register state and the extended-address pipeline stage
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            mb[0]   <= 8'h00;
            mb[1]   <= 8'h00;
            mb[2]   <= 8'h00;
            mb[3]   <= 8'h00;
            pmb0    <= 8'h00;
            pending <= 1'b0;
            en      <= RESET_EN;
            aext    <= 8'h00;
        end else begin
            // Commit first; a same-edge MB0 write below overrides pending and
            // pmb0, so the commit uses the value parked before this edge and
            // the new write stays outstanding.
            if (fetch_commit && pending) begin
                mb[0]   <= pmb0;
                pending <= 1'b0;
            end

            if (wen) begin
                case (raddr)
                    RA_CTRL: en <= ibus_in[0];
                    RA_MB0: begin
                        pmb0    <= ibus_in[7:0];
                        pending <= 1'b1;
                    end
                    RA_MB1:  mb[1] <= ibus_in[7:0];
                    RA_MB2:  mb[2] <= ibus_in[7:0];
                    RA_MB3:  mb[3] <= ibus_in[7:0];
                    default: ;
                endcase
            end

            // Samples pre-edge register contents, so any write shows up on
            // aext one edge after it lands.
            aext <= en ? mb[bank_idx] : 8'h00;
        end
    end

    // -------------------------------------------------------------------------
    // Combinational readback
    // -------------------------------------------------------------------------
    always_comb begin
        rd_byte = 8'h00;
        rd_hit  = 1'b0;
        case (raddr)
            RA_CTRL: begin
                rd_byte = {7'b0, en};
                rd_hit  = 1'b1;
            end
            RA_MB0: begin
                rd_byte = pending ? pmb0 : mb[0];
                rd_hit  = 1'b1;
            end
            RA_MB1: begin
                rd_byte = mb[1];
                rd_hit  = 1'b1;
            end
            RA_MB2: begin
                rd_byte = mb[2];
                rd_hit  = 1'b1;
            end
            RA_MB3: begin
                rd_byte = mb[3];
                rd_hit  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        ibus_oe  = ren && rd_hit;
        ibus_out = ibus_oe ? {8'h00, rd_byte} : 16'h0000;
    end

endmodule
